// File: rtl/seq_mult_csa.sv
// Iterative multiplier: retires BITS_PER_CYCLE multiplier bits per clock into a
// carry-save sum/carry pair, resolved with one carry-propagate add at the end.
module seq_mult_csa #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2,
    parameter int SIGNED_EN      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int ITER = WIDTH / BITS_PER_CYCLE;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int PW   = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_mcand;
    logic [PW-1:0]   r_sum;
    logic [PW-1:0]   r_carry;
    logic [PW-1:0]   r_p;
    logic [WIDTH-1:0] r_b;
    logic            r_signed;
    logic [PW-1:0]   w_sumNext;
    logic [PW-1:0]   w_carryNext;
    logic [PW-1:0]   w_pp;
    logic [PW-1:0]   w_maj;
    logic            w_negate;
    logic            w_last;

    assign w_last    = (r_state == BUSY) && (r_cnt == LAST);
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign p         = r_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        if (clear) begin
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (in_valid)        w_stateNext = BUSY;
                BUSY:    if (r_cnt == LAST)   w_stateNext = DONE;
                DONE:    if (out_ready)       w_stateNext = IDLE;
                default:                      w_stateNext = IDLE;
            endcase
        end
    end

    // Chain of full-adder rows; the signed MSB row is inverted and its +1 enters
    // the freed LSB of the final carry vector.
    always_comb begin
        w_sumNext   = r_sum;
        w_carryNext = r_carry;
        w_pp        = '0;
        w_maj       = '0;
        w_negate    = 1'b0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            w_pp     = r_b[j] ? (r_mcand << j) : '0;
            w_negate = r_signed && (r_cnt == LAST) && (j == BITS_PER_CYCLE - 1);
            if (w_negate) w_pp = ~w_pp;
            w_maj       = (w_sumNext & w_carryNext) | (w_sumNext & w_pp) | (w_carryNext & w_pp);
            w_sumNext   = w_sumNext ^ w_carryNext ^ w_pp;
            w_carryNext = {w_maj[PW-2:0], w_negate};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_sum    <= '0;
            r_carry  <= '0;
            r_p      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
        end else if (clear) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_signed <= (SIGNED_EN != 0) && signed_mode;
                        r_mcand  <= ((SIGNED_EN != 0) && signed_mode) ?
                                    {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
                        r_b      <= b;
                        r_sum    <= '0;
                        r_carry  <= '0;
                        r_cnt    <= '0;
                    end
                end
                BUSY: begin
                    r_sum   <= w_sumNext;
                    r_carry <= w_carryNext;
                    r_mcand <= r_mcand << BITS_PER_CYCLE;
                    r_b     <= r_b >> BITS_PER_CYCLE;
                    if (w_last) begin
                        r_p   <= w_sumNext + w_carryNext;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_csa.sv
// Self-checking bench for seq_mult_csa: directed 8-bit cases plus random 16-bit
// operands on three configurations, checked against a plain-arithmetic model.
module tb_seq_mult_csa;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        iv8 = 1'b0, sm8 = 1'b0, or8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ir8, ov8;
    logic [15:0] p8;

    logic        iv16 = 1'b0, sm16 = 1'b0, or16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [2:0]  ir16, ov16;
    logic [31:0] p16 [3];
    int          lat16Exp [3] = '{16, 4, 8};
    bit          se16 [3]     = '{1'b1, 1'b1, 1'b0};

    seq_mult_csa #(.WIDTH(8), .BITS_PER_CYCLE(2), .SIGNED_EN(1)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .signed_mode(sm8), .clear(clear), .out_valid(ov8), .out_ready(or8), .p(p8));

    seq_mult_csa #(.WIDTH(16), .BITS_PER_CYCLE(1), .SIGNED_EN(1)) u16b1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16[0]), .a(a16), .b(b16),
        .signed_mode(sm16), .clear(1'b0), .out_valid(ov16[0]), .out_ready(or16), .p(p16[0]));

    seq_mult_csa #(.WIDTH(16), .BITS_PER_CYCLE(4), .SIGNED_EN(1)) u16b4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16[1]), .a(a16), .b(b16),
        .signed_mode(sm16), .clear(1'b0), .out_valid(ov16[1]), .out_ready(or16), .p(p16[1]));

    seq_mult_csa #(.WIDTH(16), .BITS_PER_CYCLE(2), .SIGNED_EN(0)) u16s0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16[2]), .a(a16), .b(b16),
        .signed_mode(sm16), .clear(1'b0), .out_valid(ov16[2]), .out_ready(or16), .p(p16[2]));

    // Reference product: interpret operands as integers, multiply, keep 2*w bits.
    function automatic logic [63:0] refMul(input logic [31:0] a, input logic [31:0] b,
                                           input bit sgn, input int w);
        longint sa, sb, prod, mask;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        prod = sa * sb;
        mask = (longint'(1) << (2 * w)) - 1;
        return 64'(prod & mask);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One 8-bit transaction; operands are scrambled while busy, DONE is held for 'hold' cycles.
    task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input bit sm,
                                  input int hold, input logic [15:0] pExp, input string tag);
        int          lat = 0;
        bit          busyOk = 1'b1;
        bit          stable = 1'b1;
        logic [15:0] pSeen;
        a8 = a; b8 = b; sm8 = sm; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
            @(posedge clk); #1;
            if (ov8) lat = k;
            else if (ir8) busyOk = 1'b0;
        end
        checkOutput({tag, ".lat"}, 64'(lat), 64'd4);
        checkOutput({tag, ".busyReady"}, 64'(busyOk), 64'd1);
        checkOutput({tag, ".p"}, 64'(p8), 64'(pExp));
        checkOutput({tag, ".doneReady"}, 64'(ir8), 64'd0);
        pSeen = p8;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (!ov8 || p8 !== pSeen) stable = 1'b0;
        end
        if (hold > 0) checkOutput({tag, ".holdStable"}, 64'(stable), 64'd1);
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        checkOutput({tag, ".idleReady"}, 64'(ir8), 64'd1);
        checkOutput({tag, ".idleValid"}, 64'(ov8), 64'd0);
    endtask

    // One 16-bit transaction presented to all three 16-bit configurations at once.
    task automatic applyStimulus16(input logic [15:0] a, input logic [15:0] b, input bit sm,
                                   input string tag);
        logic [63:0] e [3];
        int          lat [3];
        for (int i = 0; i < 3; i++) begin
            e[i]   = refMul(32'(a), 32'(b), sm && se16[i], 16);
            lat[i] = 0;
        end
        a16 = a; b16 = b; sm16 = sm; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        for (int k = 1; k <= 40 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0); k++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++)
                if (lat[i] == 0 && ov16[i]) lat[i] = k;
        end
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s.lat%0d", tag, i), 64'(lat[i]), 64'(lat16Exp[i]));
            checkOutput($sformatf("%s.p%0d", tag, i), 64'(p16[i]), e[i]);
        end
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        checkOutput({tag, ".idleReady"}, 64'(ir16), 64'd7);
    endtask

    initial begin
        logic [15:0] pOld;
        logic [7:0]  ra, rb;
        bit          rs;
        bit          seenValid;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset.ready8", 64'(ir8), 64'd1);
        checkOutput("reset.valid8", 64'(ov8), 64'd0);
        checkOutput("reset.p8", 64'(p8), 64'd0);
        checkOutput("reset.ready16", 64'(ir16), 64'd7);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus8(8'hFF, 8'hFF, 1'b0, 0, 16'hFE01, "u_ffxff");
        applyStimulus8(8'h80, 8'h80, 1'b1, 10, 16'(refMul(32'h80, 32'h80, 1'b1, 8)), "s_80x80");
        applyStimulus8(8'hFF, 8'h01, 1'b1, 0, 16'(refMul(32'hFF, 32'h01, 1'b1, 8)), "s_ffx01");
        applyStimulus8(8'h7F, 8'h81, 1'b1, 0, 16'(refMul(32'h7F, 32'h81, 1'b1, 8)), "s_7fx81");
        for (int n = 0; n < 12; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            applyStimulus8(ra, rb, rs, 0, 16'(refMul(32'(ra), 32'(rb), rs, 8)),
                           $sformatf("r8_%0d", n));
        end

        // Abort on the second busy edge, then a refused accept under clear.
        pOld = p8;
        a8 = 8'h0F; b8 = 8'h0F; sm8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checkOutput("clr.ready", 64'(ir8), 64'd1);
        checkOutput("clr.valid", 64'(ov8), 64'd0);
        checkOutput("clr.pKept", 64'(p8), 64'(pOld));
        iv8 = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0; clear = 1'b0;
        checkOutput("clr.noAccept", 64'(ir8), 64'd1);
        seenValid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ov8) seenValid = 1'b1;
        end
        checkOutput("clr.neverValid", 64'(seenValid), 64'd0);
        checkOutput("clr.pStill", 64'(p8), 64'(pOld));
        applyStimulus8(8'd3, 8'd5, 1'b0, 0, 16'd15, "clr_3x5");

        // Asynchronous reset between edges while busy.
        a8 = 8'hA5; b8 = 8'h5A; sm8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst.valid", 64'(ov8), 64'd0);
        checkOutput("arst.ready", 64'(ir8), 64'd1);
        checkOutput("arst.p", 64'(p8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus8(8'h12, 8'h34, 1'b0, 0, 16'h03A8, "arst_12x34");

        applyStimulus16(16'hFFFF, 16'hFFFF, 1'b0, "w16_ffff_u");
        applyStimulus16(16'hFFFF, 16'hFFFF, 1'b1, "w16_ffff_s");
        applyStimulus16(16'h8000, 16'h8000, 1'b1, "w16_8000_s");
        applyStimulus16(16'h7FFF, 16'h8000, 1'b1, "w16_7fff_s");
        for (int n = 0; n < 500; n++)
            applyStimulus16(16'($urandom), 16'($urandom), 1'($urandom), $sformatf("r16_%0d", n));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
